h264_mb_fetch: RTL and testbench
================================

# h264_mb_fetch

Macroblock fetch stage sitting directly upstream of the H.264 encoder core. On a start pulse it reads one 4:2:0 macroblock from planar YUV frame memory as 32-bit words: 64 luma words, 16 Cb words and 16 Cr words. It unpacks them into a 16×16 Y matrix and two 8×8 chroma matrices, then pulses a finish flag. The intra-prediction and transform stages consume the matrices.

## Interface
- FRAME_W_MB, 11, frame width in macroblocks (QCIF default)
- FRAME_H_MB, 9, frame height in macroblocks
- Y_BASE, 0, word address of first luma word; Cb plane at Y_BASE+64·W·H; Cr plane at Cb base+16·W·H, where W=FRAME_W_MB and H=FRAME_H_MB
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_start  in  1  request pulse; sampled in IDLE only
- fetch_mb_x  in  6  macroblock column, sampled with fetch_start
- fetch_mb_y  in  6  macroblock row, sampled with fetch_start
- fetch_addr  out  32  word address to frame memory
- data_valid  in  1  data_word holds mem[fetch_addr] this cycle
- data_word  in  32  memory word; bits [31:24] are the leftmost pixel
- matrixY  out  8×[16][16]  luma samples [row][col]
- matrixU  out  8×[8][8]  Cb samples
- matrixV  out  8×[8][8]  Cr samples
- fetch_busy  out  1  high from the cycle after acceptance through DONE
- fetch_finish  out  1  one-cycle pulse when all 96 words have been captured
- fetch_err  out  1  one-cycle pulse when a request is out of range

## Operation
- States: IDLE → Y → U → V → DONE → IDLE.
- **IDLE.** When fetch_start=1:
  - If mb_x≥FRAME_W_MB or mb_y≥FRAME_H_MB: pulse fetch_err next cycle and stay in IDLE.
  - Otherwise latch the coordinates, clear the word counter and go to Y.
- **Word counter.** One counter per plane, c = word index within the macroblock.
- **Y, 64 words.** r=c[5:2], w=c[1:0].
  - fetch_addr = Y_BASE + (mb_y·16+r)·4W + mb_x·4 + w.
  - The captured word fills matrixY[r][4w..4w+3].
- **U, 16 words.** r=c[3:1], w=c[0].
  - fetch_addr = U_BASE + (mb_y·8+r)·2W + mb_x·2 + w.
  - The captured word fills matrixU[r][4w..4w+3].
- **V, 16 words.** Same as U, with V_BASE and matrixV.
- **Capture rule.** A word is captured, and the counter advances, only on cycles with data_valid=1. When data_valid=0, fetch_addr holds its value.
- **Plane transitions.** The last word of a plane moves the FSM to the next state on the same edge, with the counter cleared.
- **DONE.** Lasts one cycle; fetch_finish=1 during it.
- **Matrix updates.** Matrices are written in place as words arrive and otherwise hold their value. Consumers read them only after fetch_finish.
- **Ignored requests.** fetch_start in any state other than IDLE is ignored, including during DONE.
- **Reset.** rst in any state forces IDLE.
  - Zeroed outputs: fetch_addr, every matrix entry, fetch_busy, fetch_finish, fetch_err.
  - Latched coordinates and counter are also zeroed.
- **Address arithmetic.** Computed in 32-bit unsigned with no wrap for legal parameters. Multiplies use constant parameters, so only mb_x/mb_y terms vary.

## Timing
- fetch_addr is a registered output. It is valid in the first Y cycle, one cycle after acceptance.
- data_word is combinational from fetch_addr: zero-latency memory, sampled on the same edge.
- With data_valid held at 1 and acceptance at cycle 0:
  - Y words are captured in cycles 1–64, U in 65–80, V in 81–96.
  - fetch_finish=1 in cycle 97.
  - A new fetch_start is accepted in cycle 98, once the FSM is back in IDLE.
- Each data_valid=0 cycle adds exactly one cycle of latency.
- fetch_err is asserted in cycle 1 for a request sampled in cycle 0.

## Structure
- Shared package h264_pkg holds:
  - fetch_state_e {IDLE, Y, U, V, DONE}
  - MB_SIZE=16, CHROMA_SIZE=8, WORDS_PER_MB=96
  - matrix typedefs for luma and chroma
- One sub-module, h264_mb_addr_gen. It is combinational: plane, counter and coordinates in, next fetch_addr out. It is registered in the parent.

## Test plan
- **Basic fetch.** Memory mem[i]=i, mb (0,0), data_valid=1.
  - Addresses 0,1,2,3,44,… (4W=44), then U base 6336, then V base 7920.
  - fetch_finish in cycle 97.
  - matrixY[1][0]=8'h00, the top byte of word 44.
- **Last macroblock.** mb (10,8).
  - First Y address = 8·16·44 + 40 = 5672.
  - Last V address = 7920 + 71·22 + 21 = 9503.
- **Stalls.** data_valid random with 50% duty.
  - No word is dropped or duplicated.
  - Latency = 97 + number of stall cycles.
  - Matrices match the stall-free run.
- **Start while busy.** fetch_start pulsed at cycles 10 and 97.
  - Both are ignored.
  - fetch_addr sequence unchanged.
- **Out-of-range request.** mb (11,0) → fetch_err=1 for one cycle, fetch_busy stays 0, no address change.
- **Reset mid-fetch.** rst at cycle 40.
  - Next cycle: all outputs 0, state IDLE.
  - A subsequent fetch of mb (0,0) completes correctly.

Source files
------------

// File: rtl/h264_pkg.sv
// Shared types and constants for the H.264 macroblock fetch stage.
// Matrices are packed [row][col][byte] so they can travel through interface ports.
package h264_pkg;

    typedef enum logic [2:0] {IDLE, Y, U, V, DONE} fetch_state_e;

    localparam int MB_SIZE      = 16;
    localparam int CHROMA_SIZE  = 8;
    localparam int WORDS_PER_MB = 96;

    typedef logic [MB_SIZE-1:0][MB_SIZE-1:0][7:0]         luma_mat_t;
    typedef logic [CHROMA_SIZE-1:0][CHROMA_SIZE-1:0][7:0] chroma_mat_t;

endpackage

// File: rtl/h264_mb_fetch_if.sv
// Request, frame-memory and matrix signals of the macroblock fetch stage.
// The fetch block is the slave; the requester/memory side is the master.
interface h264_mb_fetch_if;
    import h264_pkg::*;

    logic        fetch_start;
    logic [5:0]  fetch_mb_x;
    logic [5:0]  fetch_mb_y;
    logic [31:0] fetch_addr;
    logic        data_valid;
    logic [31:0] data_word;
    luma_mat_t   matrixY;
    chroma_mat_t matrixU;
    chroma_mat_t matrixV;
    logic        fetch_busy;
    logic        fetch_finish;
    logic        fetch_err;

    modport master (
        output fetch_start, fetch_mb_x, fetch_mb_y, data_valid, data_word,
        input  fetch_addr, matrixY, matrixU, matrixV,
        input  fetch_busy, fetch_finish, fetch_err
    );

    modport slave (
        input  fetch_start, fetch_mb_x, fetch_mb_y, data_valid, data_word,
        output fetch_addr, matrixY, matrixU, matrixV,
        output fetch_busy, fetch_finish, fetch_err
    );

endinterface

// File: rtl/h264_mb_addr_gen.sv
// Combinational frame-memory word address for a plane, word index and macroblock.
// Plane pitches and bases are constants, so only the coordinate terms vary.
module h264_mb_addr_gen
    import h264_pkg::*;
#(
    parameter int unsigned FRAME_W_MB = 11,
    parameter int unsigned FRAME_H_MB = 9,
    parameter int unsigned Y_BASE     = 0
) (
    input  fetch_state_e plane,
    input  logic [5:0]   cnt,
    input  logic [5:0]   mb_x,
    input  logic [5:0]   mb_y,
    output logic [31:0]  addr
);

    localparam logic [31:0] U_BASE  = 32'(Y_BASE + 64 * FRAME_W_MB * FRAME_H_MB);
    localparam logic [31:0] V_BASE  = U_BASE + 32'(16 * FRAME_W_MB * FRAME_H_MB);
    localparam logic [31:0] Y_PITCH = 32'(4 * FRAME_W_MB);
    localparam logic [31:0] C_PITCH = 32'(2 * FRAME_W_MB);

    logic [31:0] x32;
    logic [31:0] y32;
    logic [31:0] c_off;

    assign x32   = 32'(mb_x);
    assign y32   = 32'(mb_y);
    // Cb and Cr share the same in-plane offset; only the base differs
    assign c_off = (y32 * 32'd8 + 32'(cnt[3:1])) * C_PITCH + x32 * 32'd2 + 32'(cnt[0]);

    always_comb begin
        addr = '0;
        case (plane)
            Y:       addr = 32'(Y_BASE) + (y32 * 32'd16 + 32'(cnt[5:2])) * Y_PITCH
                            + x32 * 32'd4 + 32'(cnt[1:0]);
            U:       addr = U_BASE + c_off;
            V:       addr = V_BASE + c_off;
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/h264_mb_fetch.sv
// Fetches one 4:2:0 macroblock (64 Y, 16 Cb, 16 Cr words) and unpacks it into
// sample matrices; the next address is precomputed so fetch_addr stays registered.
module h264_mb_fetch
    import h264_pkg::*;
#(
    parameter int unsigned FRAME_W_MB = 11,
    parameter int unsigned FRAME_H_MB = 9,
    parameter int unsigned Y_BASE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    h264_mb_fetch_if.slave    bus
);

    localparam int Y_WORDS = MB_SIZE * MB_SIZE / 4;
    localparam int C_WORDS = (WORDS_PER_MB - Y_WORDS) / 2;

    fetch_state_e state;
    fetch_state_e nxt_plane;
    logic [5:0]   cnt;
    logic [5:0]   nxt_cnt;
    logic [5:0]   mb_x_q;
    logic [5:0]   mb_y_q;
    logic [5:0]   nxt_x;
    logic [5:0]   nxt_y;
    logic [31:0]  nxt_addr;
    logic         in_range;
    logic         accept;
    logic         capture;
    logic         last_word;

    assign in_range  = (32'(bus.fetch_mb_x) < FRAME_W_MB) && (32'(bus.fetch_mb_y) < FRAME_H_MB);
    assign accept    = (state == IDLE) && bus.fetch_start && in_range;
    assign capture   = bus.data_valid && (state inside {Y, U, V});
    assign last_word = (state == Y) ? (cnt == 6'(Y_WORDS - 1)) : (cnt == 6'(C_WORDS - 1));

    // Where the fetch will be after this edge, used to look up the next address
    always_comb begin
        nxt_plane = state;
        nxt_cnt   = cnt;
        nxt_x     = mb_x_q;
        nxt_y     = mb_y_q;
        if (accept) begin
            nxt_plane = Y;
            nxt_cnt   = '0;
            nxt_x     = bus.fetch_mb_x;
            nxt_y     = bus.fetch_mb_y;
        end else if (capture) begin
            if (last_word) begin
                nxt_cnt = '0;
                case (state)
                    Y:       nxt_plane = U;
                    U:       nxt_plane = V;
                    default: nxt_plane = DONE;
                endcase
            end else begin
                nxt_cnt = cnt + 6'd1;
            end
        end
    end

    h264_mb_addr_gen #(
        .FRAME_W_MB (FRAME_W_MB),
        .FRAME_H_MB (FRAME_H_MB),
        .Y_BASE     (Y_BASE)
    ) u_addr_gen (
        .plane (nxt_plane),
        .cnt   (nxt_cnt),
        .mb_x  (nxt_x),
        .mb_y  (nxt_y),
        .addr  (nxt_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            mb_x_q           <= '0;
            mb_y_q           <= '0;
            bus.fetch_addr   <= '0;
            bus.matrixY      <= '0;
            bus.matrixU      <= '0;
            bus.matrixV      <= '0;
            bus.fetch_busy   <= 1'b0;
            bus.fetch_finish <= 1'b0;
            bus.fetch_err    <= 1'b0;
        end else begin
            bus.fetch_finish <= 1'b0;
            bus.fetch_err    <= 1'b0;
            // After the final Cr word the address simply holds
            if (accept || (capture && nxt_plane != DONE)) begin
                bus.fetch_addr <= nxt_addr;
            end
            case (state)
                IDLE: begin
                    if (bus.fetch_start) begin
                        if (in_range) begin
                            state          <= Y;
                            cnt            <= nxt_cnt;
                            mb_x_q         <= nxt_x;
                            mb_y_q         <= nxt_y;
                            bus.fetch_busy <= 1'b1;
                        end else begin
                            bus.fetch_err  <= 1'b1;
                        end
                    end
                end
                Y, U, V: begin
                    if (bus.data_valid) begin
                        for (int k = 0; k < 4; k++) begin
                            if (state == Y) begin
                                bus.matrixY[cnt[5:2]][{cnt[1:0], 2'(k)}] <= bus.data_word[8*(3-k) +: 8];
                            end else if (state == U) begin
                                bus.matrixU[cnt[3:1]][{cnt[0], 2'(k)}] <= bus.data_word[8*(3-k) +: 8];
                            end else begin
                                bus.matrixV[cnt[3:1]][{cnt[0], 2'(k)}] <= bus.data_word[8*(3-k) +: 8];
                            end
                        end
                        state <= nxt_plane;
                        cnt   <= nxt_cnt;
                        if (nxt_plane == DONE) begin
                            bus.fetch_finish <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    bus.fetch_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_h264_mb_fetch.sv
// Directed bench for h264_mb_fetch: a vector table of macroblock requests plus
// hand-written sequences for basic fetch, start-while-busy and reset mid-fetch.
module tb_h264_mb_fetch;
    import h264_pkg::*;

    localparam int W  = 11;
    localparam int H  = 9;
    localparam int UB = 64 * W * H;
    localparam int VB = UB + 16 * W * H;

    typedef struct {
        int          x;
        int          y;
        bit          stall;
        bit          err;
        logic [31:0] first_y;
        logic [31:0] first_u;
        logic [31:0] last_v;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mem_mode = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    int          res_lat, res_stalls, res_addr_errs;
    logic [31:0] res_first_y, res_first_u, res_first_v, res_last_v;
    bit          res_timeout, res_busy1, res_busy_end, res_finish_end;

    h264_mb_fetch_if bus ();

    h264_mb_fetch #(
        .FRAME_W_MB (W),
        .FRAME_H_MB (H),
        .Y_BASE     (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a, input bit m);
        return m ? ((a * 32'h9E3779B1) ^ 32'h5A5AC3C3) : a;
    endfunction

    // Zero-latency frame memory
    assign bus.data_word = memWord(bus.fetch_addr, mem_mode);

    function automatic logic [31:0] modelAddr(input int k, input int x, input int y);
        int j;
        if (k < 64) return 32'((y * 16 + k / 4) * 4 * W + x * 4 + k % 4);
        j = (k < 80) ? k - 64 : k - 80;
        return 32'(((k < 80) ? UB : VB) + (y * 8 + j / 2) * 2 * W + x * 2 + j % 2);
    endfunction

    function automatic logic [7:0] modelByte(input int k, input int b, input int x, input int y);
        logic [31:0] wd;
        wd = memWord(modelAddr(k, x, y), mem_mode);
        return wd[8*(3-b) +: 8];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic checkMatrices(input int x, input int y, input bit expect_zero, input string tag);
        int bad_y = 0;
        int bad_u = 0;
        int bad_v = 0;
        logic [7:0] e;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                e = expect_zero ? 8'h00 : modelByte(r * 4 + c / 4, c % 4, x, y);
                if (bus.matrixY[r][c] !== e) bad_y++;
            end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                e = expect_zero ? 8'h00 : modelByte(64 + r * 2 + c / 4, c % 4, x, y);
                if (bus.matrixU[r][c] !== e) bad_u++;
                e = expect_zero ? 8'h00 : modelByte(80 + r * 2 + c / 4, c % 4, x, y);
                if (bus.matrixV[r][c] !== e) bad_v++;
            end
        checkOutput({tag, " matrixY bad entries"}, bad_y, 0);
        checkOutput({tag, " matrixU bad entries"}, bad_u, 0);
        checkOutput({tag, " matrixV bad entries"}, bad_v, 0);
    endtask

    // Runs one full fetch; poke re-pulses fetch_start at cycles 10 and 97
    task automatic applyStimulus(input int x, input int y, input bit stall, input bit poke);
        int cyc;
        int k;
        bit dv;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        bus.fetch_mb_x  = 6'(x);
        bus.fetch_mb_y  = 6'(y);
        bus.data_valid  = 1'b0;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        cyc = 1;
        k = 0;
        res_stalls = 0;
        res_addr_errs = 0;
        res_timeout = 1'b0;
        res_busy1 = bus.fetch_busy;
        while (1) begin
            if (poke) begin
                bus.fetch_start = (cyc == 10 || cyc == 97);
                bus.fetch_mb_x  = 6'd0;
                bus.fetch_mb_y  = 6'd0;
            end
            if (bus.fetch_finish) break;
            if (cyc > 1000) begin
                res_timeout = 1'b1;
                break;
            end
            if (k < 96) begin
                if (bus.fetch_addr !== modelAddr(k, x, y)) res_addr_errs++;
                if (k == 0)  res_first_y = bus.fetch_addr;
                if (k == 64) res_first_u = bus.fetch_addr;
                if (k == 80) res_first_v = bus.fetch_addr;
                if (k == 95) res_last_v  = bus.fetch_addr;
            end
            dv = (stall && k < 96) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_valid = dv;
            if (!dv) res_stalls++;
            else if (k < 96) k++;
            @(negedge clk);
            cyc++;
        end
        res_lat = cyc;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        bus.data_valid  = 1'b0;
        res_busy_end    = bus.fetch_busy;
        res_finish_end  = bus.fetch_finish;
    endtask

    task automatic checkFetch(input string tag, input vec_t v);
        checkOutput({tag, " timeout"}, 32'(res_timeout), 0);
        checkOutput({tag, " addr_seq errors"}, res_addr_errs, 0);
        checkOutput({tag, " first_y_addr"}, res_first_y, v.first_y);
        checkOutput({tag, " first_u_addr"}, res_first_u, v.first_u);
        checkOutput({tag, " last_v_addr"}, res_last_v, v.last_v);
        checkOutput({tag, " latency"}, res_lat, 97 + res_stalls);
        checkOutput({tag, " busy_cycle1"}, 32'(res_busy1), 1);
        checkOutput({tag, " busy_after_done"}, 32'(res_busy_end), 0);
        checkOutput({tag, " finish_one_cycle"}, 32'(res_finish_end), 0);
        checkMatrices(v.x, v.y, 1'b0, tag);
    endtask

    initial begin
        vec_t        vecs[8];
        vec_t        v;
        logic [31:0] addr_before;

        vecs[0] = '{0, 0, 1'b0, 1'b0, 32'd0, 32'd6336, 32'd8075};
        vecs[1] = '{10, 8, 1'b0, 1'b0, 32'd5672, 32'd7764, 32'd9503};
        vecs[2] = '{3, 2, 1'b1, 1'b0, 32'd1420, 32'd6694, 32'd8433};
        vecs[3] = '{5, 1, 1'b0, 1'b0, 32'd724, 32'd6522, 32'd8261};
        vecs[4] = '{11, 0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0};
        vecs[5] = '{0, 9, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0};
        vecs[6] = '{63, 63, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0};
        vecs[7] = '{10, 8, 1'b1, 1'b0, 32'd5672, 32'd7764, 32'd9503};

        bus.fetch_start = 1'b0;
        bus.fetch_mb_x  = 6'd0;
        bus.fetch_mb_y  = 6'd0;
        bus.data_valid  = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset fetch_addr", bus.fetch_addr, 0);
        checkOutput("reset fetch_busy", 32'(bus.fetch_busy), 0);
        checkOutput("reset fetch_finish", 32'(bus.fetch_finish), 0);
        checkOutput("reset fetch_err", 32'(bus.fetch_err), 0);
        checkMatrices(0, 0, 1'b1, "reset");
        rst = 1'b0;

        $display("[TB] basic fetch, mem[i]=i");
        mem_mode = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkFetch("basic", vecs[0]);
        checkOutput("basic first_v_addr", res_first_v, 7920);
        checkOutput("basic latency_exact", res_lat, 97);
        checkOutput("basic matrixY[1][0]", 32'(bus.matrixY[1][0]), 32'h00);
        checkOutput("basic matrixY[1][3]", 32'(bus.matrixY[1][3]), 32'd44);
        checkOutput("basic matrixY[0][7]", 32'(bus.matrixY[0][7]), 32'h01);

        $display("[TB] vector table");
        mem_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            if (v.err) begin
                addr_before = bus.fetch_addr;
                @(negedge clk);
                bus.fetch_start = 1'b1;
                bus.fetch_mb_x  = 6'(v.x);
                bus.fetch_mb_y  = 6'(v.y);
                bus.data_valid  = 1'b1;
                @(negedge clk);
                bus.fetch_start = 1'b0;
                checkOutput($sformatf("vec%0d fetch_err", i), 32'(bus.fetch_err), 1);
                checkOutput($sformatf("vec%0d busy_on_err", i), 32'(bus.fetch_busy), 0);
                checkOutput($sformatf("vec%0d addr_on_err", i), bus.fetch_addr, addr_before);
                @(negedge clk);
                bus.data_valid = 1'b0;
                checkOutput($sformatf("vec%0d err_one_cycle", i), 32'(bus.fetch_err), 0);
                checkOutput($sformatf("vec%0d busy_after_err", i), 32'(bus.fetch_busy), 0);
            end else begin
                applyStimulus(v.x, v.y, v.stall, 1'b0);
                checkFetch($sformatf("vec%0d", i), v);
            end
        end

        $display("[TB] start while busy");
        v = '{2, 1, 1'b0, 1'b0, 32'd712, 32'd6516, 32'd8255};
        applyStimulus(v.x, v.y, 1'b0, 1'b1);
        checkFetch("busy_start", v);
        @(negedge clk);
        checkOutput("busy_start idle_busy", 32'(bus.fetch_busy), 0);
        checkOutput("busy_start addr_held", bus.fetch_addr, 32'd8255);

        $display("[TB] reset mid-fetch");
        @(negedge clk);
        bus.fetch_start = 1'b1;
        bus.fetch_mb_x  = 6'd4;
        bus.fetch_mb_y  = 6'd3;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        bus.data_valid  = 1'b1;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        checkOutput("midrst fetch_addr", bus.fetch_addr, 0);
        checkOutput("midrst fetch_busy", 32'(bus.fetch_busy), 0);
        checkOutput("midrst fetch_finish", 32'(bus.fetch_finish), 0);
        checkOutput("midrst fetch_err", 32'(bus.fetch_err), 0);
        checkMatrices(0, 0, 1'b1, "midrst");
        rst = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkFetch("after_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
